// File: rtl/sign_mag_add_pkg.sv
// Shared constants for the sign-magnitude adder.
// Optional build macro: SIGN_MAG_ADD_SAT_EN (saturate on overflow instead of wrap).
package sign_mag_pkg;

  // Default word width, including the sign bit.
  localparam int SMA_N   = 4;
  localparam int MAG_W   = SMA_N - 1;
  localparam int MAG_MAX = (2 ** MAG_W) - 1;

  // Values of the sign bit.
  localparam logic POS = 1'b0;
  localparam logic NEG = 1'b1;

endpackage

// File: rtl/sign_mag_add_core.sv
// Combinational sign-magnitude add: compare, add/subtract, sign select,
// zero normalisation and overflow wrap/saturate.
// Optional build macro: SIGN_MAG_ADD_SAT_EN (saturate on overflow instead of wrap).
module sign_mag_add_core
  import sign_mag_pkg::*;
#(
  parameter int N = SMA_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);

  localparam int MW = N - 1;

  logic          sa;
  logic          sb;
  logic [MW-1:0] ma;
  logic [MW-1:0] mb;
  logic [N-1:0]  add_w;
  logic [MW-1:0] mag;
  logic          sgn;

  // Operand split and the magnitude sum, one bit wider than a magnitude.
  always_comb begin
    sa    = a[N-1];
    sb    = b[N-1];
    ma    = a[MW-1:0];
    mb    = b[MW-1:0];
    add_w = {1'b0, ma} + {1'b0, mb};
  end

  // Select magnitude and sign, then normalise zero and handle overflow.
  always_comb begin
    mag = '0;
    sgn = POS;
    ovf = 1'b0;
    sum = '0;

    if (sa == sb) begin
      mag = add_w[MW-1:0];
      ovf = add_w[N-1];
      sgn = sa;
    end else if (ma > mb) begin
      mag = ma - mb;
      sgn = sa;
    end else if (mb > ma) begin
      mag = mb - ma;
      sgn = sb;
    end

    if (ovf) begin
`ifdef SIGN_MAG_ADD_SAT_EN
      sum = {sgn, {MW{1'b1}}};
`else
      sum = {sgn, mag};
`endif
    end else if (mag == '0) begin
      // Covers equal magnitudes and -0 inputs: always emit +0.
      sum = '0;
    end else begin
      sum = {sgn, mag};
    end
  end

endmodule

// File: rtl/sign_mag_add.sv
// Registered sign-magnitude adder, one-cycle latency, magnitude overflow flag.
// Optional build macro: SIGN_MAG_ADD_SAT_EN (saturate on overflow instead of wrap).
module sign_mag_add
  import sign_mag_pkg::*;
#(
  parameter int N = SMA_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         ovf
);

  logic [N-1:0] sum_c;
  logic         ovf_c;

  sign_mag_add_core #(.N(N)) u_core (
    .a   (a),
    .b   (b),
    .sum (sum_c),
    .ovf (ovf_c)
  );

  // Capture the result on valid input; hold the last result otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= sum_c;
        ovf <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_sign_mag_add.sv
// Self-checking bench for sign_mag_add: vector table, control sequences,
// and random traffic against an integer-arithmetic reference model.
module tb_sign_mag_add;

  localparam int N       = 4;
  localparam int MAG_MAX = (2 ** (N - 1)) - 1;

`ifdef SIGN_MAG_ADD_SAT_EN
  localparam logic [N-1:0] NEG_OVF = 4'b1111;
  localparam logic [N-1:0] POS_OVF = 4'b0111;
`else
  localparam logic [N-1:0] NEG_OVF = 4'b1000;
  localparam logic [N-1:0] POS_OVF = 4'b0000;
`endif

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         o;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic [N-1:0] sum;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  sign_mag_add #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed integer sum, then the output encoding rules.
  task automatic model(input logic [N-1:0] ia, input logic [N-1:0] ib,
                       output logic [N-1:0] es, output logic eo);
    int va, vb, t, m;
    logic [N-2:0] mm;
    va = ia[N-1] ? -int'(ia[N-2:0]) : int'(ia[N-2:0]);
    vb = ib[N-1] ? -int'(ib[N-2:0]) : int'(ib[N-2:0]);
    t  = va + vb;
    m  = (t < 0) ? -t : t;
    if (m > MAG_MAX) begin
      eo = 1'b1;
`ifdef SIGN_MAG_ADD_SAT_EN
      mm = '1;
`else
      mm = (N-1)'(m % (MAG_MAX + 1));
`endif
      es = {(t < 0), mm};
    end else begin
      eo = 1'b0;
      mm = (N-1)'(m);
      es = (m == 0) ? '0 : {(t < 0), mm};
    end
  endtask

  initial begin
    vec_t         vt[$];
    logic [N-1:0] es;
    logic         eo;
    logic [N-1:0] held_s;
    logic         held_o;
    logic         v;

    vt.push_back('{4'b0011, 4'b0010, 4'b0101, 1'b0});
    vt.push_back('{4'b1011, 4'b1010, 4'b1101, 1'b0});
    vt.push_back('{4'b0101, 4'b1010, 4'b0011, 1'b0});
    vt.push_back('{4'b1101, 4'b0010, 4'b1011, 1'b0});
    vt.push_back('{4'b0101, 4'b1101, 4'b0000, 1'b0});
    vt.push_back('{4'b0000, 4'b1010, 4'b1010, 1'b0});
    vt.push_back('{4'b1111, 4'b1001, NEG_OVF, 1'b1});
    vt.push_back('{4'b0100, 4'b0100, POS_OVF, 1'b1});
    vt.push_back('{4'b0011, 4'b0100, 4'b0111, 1'b0});
    vt.push_back('{4'b1000, 4'b1000, 4'b0000, 1'b0});
    vt.push_back('{4'b0000, 4'b1000, 4'b0000, 1'b0});
    vt.push_back('{4'b1000, 4'b0011, 4'b0011, 1'b0});
    vt.push_back('{4'b0111, 4'b1111, 4'b0000, 1'b0});

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #2;
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("reset_hold_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;

    // Back-to-back table vectors.
    for (int i = 0; i < vt.size(); i++) begin
      in_valid = 1'b1;
      a = vt[i].a;
      b = vt[i].b;
      @(posedge clk); #1;
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vt[i].s));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].o));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    end

    // Hold while in_valid is low, even with changing operands.
    in_valid = 1'b1; a = 4'b1111; b = 4'b1001;
    @(posedge clk); #1;
    held_s = sum; held_o = ovf;
    check("hold_setup_ovf", 32'(ovf), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 4'(i + 1); b = 4'(i + 2);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd0);
      check("hold_sum", 32'(sum), 32'(NEG_OVF));
      check("hold_ovf", 32'(ovf), 32'(held_o));
    end

    // Async reset mid-stream: immediate clear, in-flight result discarded.
    in_valid = 1'b1; a = 4'b1111; b = 4'b1001;
    @(posedge clk); #1;
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    a = 4'b0011; b = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("rst_inflight_sum", 32'(sum), 32'd0);
    check("rst_inflight_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Random traffic with random in_valid, against the model.
    held_s = '0; held_o = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v;
      a = N'($urandom);
      b = N'($urandom);
      if (v) begin
        model(a, b, es, eo);
        held_s = es;
        held_o = eo;
      end
      @(posedge clk); #1;
      check("rnd_valid", 32'(out_valid), 32'(v));
      check("rnd_sum", 32'(sum), 32'(held_s));
      check("rnd_ovf", 32'(ovf), 32'(held_o));
    end

    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
